// File: rtl/seg_scan_ctrl.sv
// Scan controller for the 8-digit common-anode seven-segment display: steps the digit select,
// swaps display words only at frame boundaries, and handles blanking and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int DIV_CNT   = 100000,
  parameter int WIDTH_DIV = 17
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  blank_mask,
  input  logic        lz_en,
  input  logic [3:0]  hex,
  output logic [31:0] data_q,
  output logic [2:0]  sel,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        load_ack,
  output logic        frame_done
);

  localparam logic [WIDTH_DIV-1:0] DIV_LAST = WIDTH_DIV'(DIV_CNT - 1);

  logic [WIDTH_DIV-1:0] div_cnt;
  logic [31:0]          shadow;
  logic                 pending;
  logic                 tick;
  logic                 wrap;
  logic [7:0]           upper_zero;
  logic [7:0]           lz_off;
  logic                 digit_on;

  // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = (div_cnt == DIV_LAST);
  assign wrap = tick && (sel == 3'd7);

  // upper_zero[i] is set when nibbles i..7 of the shown word are all zero.
  always_comb begin
    upper_zero    = '0;
    upper_zero[7] = (data_q[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (data_q[4*i +: 4] == 4'h0);
    end
  end

  assign lz_off   = lz_en ? (upper_zero & 8'hFE) : 8'h00;
  assign digit_on = !blank_mask[sel] && !lz_off[sel];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt    <= '0;
      sel        <= '0;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      frame_done <= wrap;
      if (tick) begin
        sel <= sel + 3'd1;
      end
    end
  end

  // New words park in shadow and are promoted only on a wrap, so a frame never mixes two words.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q   <= '0;
      shadow   <= '0;
      pending  <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= load;
      if (load && wrap) begin
        data_q  <= data;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= data;
        pending <= 1'b1;
      end else if (wrap && pending) begin
        data_q  <= shadow;
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
    end else begin
      an  <= digit_on ? ~(8'b1 << sel) : 8'hFF;
      seg <= digit_on ? dec(hex) : 7'h7F;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a frame-arithmetic model of the display checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  blank_mask = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  hex;
  logic [31:0] data_q;
  logic [2:0]  sel;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        load_ack;
  logic        frame_done;

  int passCount = 0;
  int checkCount = 0;
  bit checking = 1'b0;

  seg_scan_ctrl #(.DIV_CNT(DIV), .WIDTH_DIV(3)) dut (
    .clk(clk), .rstn(rstn), .load(load), .data(data), .blank_mask(blank_mask),
    .lz_en(lz_en), .hex(hex), .data_q(data_q), .sel(sel), .an(an), .seg(seg),
    .load_ack(load_ack), .frame_done(frame_done)
  );

  // The external 8:1 nibble mux on the board.
  assign hex = data_q[{sel, 2'b00} +: 4];

  always #5 clk = ~clk;

  // Model state: cycles since reset release, the word on display, the latest unshown word.
  int          n = 0;
  logic [31:0] shown = '0;
  logic [31:0] latest = '0;
  logic        pending = 1'b0;
  logic [7:0]  expAn = 8'hFF;
  logic [6:0]  expSeg = 7'h7F;
  logic        expAck = 1'b0;
  logic        expDone = 1'b0;
  int          outSel = -1;

  function automatic logic [6:0] segFor(input logic [3:0] v);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  function automatic int modelSel(input int cycles);
    return (cycles / DIV) % 8;
  endfunction

  function automatic bit wrapAt(input int cycles);
    return (cycles % FRAME) == FRAME - 1;
  endfunction

  function automatic logic [3:0] nibbleOf(input logic [31:0] word, input int idx);
    return 4'(word >> (4 * idx));
  endfunction

  function automatic bit digitLit(input int idx, input logic [31:0] word,
                                  input logic [7:0] mask, input logic lz);
    if (mask[idx]) return 1'b0;
    if (lz && idx != 0 && (word >> (4 * idx)) == 32'h0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model advanced once per clock from the bench's own inputs.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n       <= 0;
      shown   <= '0;
      latest  <= '0;
      pending <= 1'b0;
      expAn   <= 8'hFF;
      expSeg  <= 7'h7F;
      expAck  <= 1'b0;
      expDone <= 1'b0;
      outSel  <= -1;
    end else begin
      n       <= n + 1;
      expAck  <= load;
      expDone <= wrapAt(n);
      outSel  <= modelSel(n);
      if (wrapAt(n)) begin
        if (load) shown <= data;
        else if (pending) shown <= latest;
        pending <= 1'b0;
      end else if (load) begin
        latest  <= data;
        pending <= 1'b1;
      end
      if (digitLit(modelSel(n), shown, blank_mask, lz_en)) begin
        expAn  <= ~(8'h01 << modelSel(n));
        expSeg <= segFor(nibbleOf(shown, modelSel(n)));
      end else begin
        expAn  <= 8'hFF;
        expSeg <= 7'h7F;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("sel", 32'(sel), 32'(modelSel(n)));
      checkOutput("data_q", data_q, shown);
      checkOutput("an", 32'(an), 32'(expAn));
      checkOutput("seg", 32'(seg), 32'(expSeg));
      checkOutput("load_ack", 32'(load_ack), 32'(expAck));
      checkOutput("frame_done", 32'(frame_done), 32'(expDone));
      checkOutput("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    end
  end

  task automatic applyStimulus(input logic [31:0] d);
    load = 1'b1;
    data = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic waitPhase(input int ph);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((n % FRAME) == ph) return;
      @(negedge clk);
    end
    checkOutput("waitPhase_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitFrame();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (expDone) return;
    end
    checkOutput("waitFrame_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkSlot(input int idx, input logic [7:0] anLit, input logic [6:0] segLit);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (outSel == idx) begin
        checkOutput($sformatf("slot%0d_an", idx), 32'(an), 32'(anLit));
        checkOutput($sformatf("slot%0d_seg", idx), 32'(seg), 32'(segLit));
        return;
      end
      @(negedge clk);
    end
    checkOutput("checkSlot_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checking = 1'b1;
    checkOutput("reset_an", 32'(an), 32'h0000_00FF);
    checkOutput("reset_seg", 32'(seg), 32'h0000_007F);
    checkOutput("reset_sel", 32'(sel), 32'd0);
    rstn = 1'b1;

    $display("[TB] idle scan after reset");
    checkSlot(0, 8'hFE, 7'h40);
    checkSlot(1, 8'hFD, 7'h40);
    checkSlot(7, 8'h7F, 7'h40);

    $display("[TB] mid-frame load");
    waitPhase(10);
    applyStimulus(32'h89AB_CDEF);
    checkOutput("mid_load_ack", 32'(load_ack), 32'd1);
    checkOutput("mid_load_hold", data_q, 32'h0);
    waitFrame();
    checkOutput("mid_load_swap", data_q, 32'h89AB_CDEF);
    checkOutput("mid_load_done", 32'(frame_done), 32'd1);
    checkSlot(0, 8'hFE, 7'h0E);
    checkSlot(7, 8'h7F, 7'h00);

    $display("[TB] load on wrap cycle");
    waitPhase(FRAME - 1);
    applyStimulus(32'h0000_0012);
    checkOutput("wrap_bypass", data_q, 32'h0000_0012);
    waitFrame();
    checkOutput("wrap_no_pending", data_q, 32'h0000_0012);

    $display("[TB] two loads in one frame");
    waitPhase(3);
    applyStimulus(32'h1111_1111);
    checkOutput("first_ack", 32'(load_ack), 32'd1);
    waitPhase(15);
    applyStimulus(32'h2222_2222);
    checkOutput("second_ack", 32'(load_ack), 32'd1);
    waitFrame();
    checkOutput("last_word_wins", data_q, 32'h2222_2222);
    for (int i = 0; i < 8; i++) checkSlot(i, ~(8'h01 << i), 7'h24);

    $display("[TB] leading-zero suppression");
    lz_en = 1'b1;
    applyStimulus(32'h0000_0305);
    waitFrame();
    checkSlot(0, 8'hFE, 7'h12);
    checkSlot(1, 8'hFD, 7'h40);
    checkSlot(2, 8'hFB, 7'h30);
    checkSlot(3, 8'hFF, 7'h7F);
    checkSlot(7, 8'hFF, 7'h7F);
    applyStimulus(32'h0);
    waitFrame();
    checkSlot(0, 8'hFE, 7'h40);
    checkSlot(1, 8'hFF, 7'h7F);

    $display("[TB] blanking and mid-frame reset");
    blank_mask = 8'h01;
    waitFrame();
    for (int i = 0; i < 8; i++) checkSlot(i, 8'hFF, 7'h7F);
    applyStimulus(32'hDEAD_BEEF);
    waitPhase(13);
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_an", 32'(an), 32'h0000_00FF);
    checkOutput("async_reset_seg", 32'(seg), 32'h0000_007F);
    checkOutput("async_reset_sel", 32'(sel), 32'd0);
    checkOutput("async_reset_data", data_q, 32'h0);
    @(negedge clk);
    blank_mask = 8'h00;
    lz_en = 1'b0;
    rstn = 1'b1;
    waitFrame();
    checkOutput("pending_lost", data_q, 32'h0);

    $display("[TB] randomized run");
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      load = ($urandom % 6) == 0;
      data = $urandom >> (4 * $urandom_range(0, 8));
      if (($urandom % 50) == 0) blank_mask = 8'($urandom);
      if (($urandom % 40) == 0) lz_en = ~lz_en;
      if (($urandom % 700) == 0) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
    end
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
